// File: rtl/pq_pkg.sv
// ----------------------------------------------------------------------------
// pq_pkg
// Shared definitions for the sorted priority queue.
//   beats()                  : ordering rule between two priorities; ties
//                              never beat, which preserves FIFO order among
//                              equal priorities.
//   EVICT_MODE_* constants   : values for the EVICT_ON_FULL parameter.
// ----------------------------------------------------------------------------
package pq_pkg;

    // Full-queue behaviour selectors
    localparam bit EVICT_MODE_BACKPRESSURE = 1'b0;
    localparam bit EVICT_MODE_DROP_LOSER   = 1'b1;

    // a beats b: strictly better priority under the chosen ordering
    function automatic logic beats(input logic        high_first,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        return high_first ? (a > b) : (a < b);
    endfunction

endpackage

// File: rtl/pq_insert_index.sv
// ----------------------------------------------------------------------------
// pq_insert_index
// Finds where a new entry lands in the sorted array: the first occupied slot
// whose entry the new priority beats, or `count` if it beats none.
//   new_priority  : priority of the incoming item
//   slot_priority : priorities of all slots (post-dequeue view), slot 0 = head
//   count         : occupancy of that view; slots >= count are ignored
//   index         : insert position, 0..count (count may equal DEPTH)
// ----------------------------------------------------------------------------
module pq_insert_index
    import pq_pkg::*;
#(
    parameter int DEPTH               = 16,
    parameter int PRIORITY_WIDTH      = 3,
    parameter bit HIGH_PRIORITY_FIRST = 1'b1,
    localparam int CW                 = $clog2(DEPTH + 1)
) (
    input  logic [PRIORITY_WIDTH-1:0]            new_priority,
    input  logic [DEPTH-1:0][PRIORITY_WIDTH-1:0] slot_priority,
    input  logic [CW-1:0]                        count,
    output logic [CW-1:0]                        index
);

    logic [DEPTH-1:0] beaten;

    // one comparator per slot, masked by occupancy
    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
        assign beaten[i] = (CW'(i) < count) &&
                           beats(HIGH_PRIORITY_FIRST, 32'(new_priority),
                                 32'(slot_priority[i]));
    end

    // first-set priority encoder; lowest index wins
    always_comb begin
        index = count;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (beaten[i]) index = CW'(i);
        end
    end

endmodule

// File: rtl/aging_free_evicting_priority_queue.sv
// ----------------------------------------------------------------------------
// aging_free_evicting_priority_queue
// Sorted priority queue, slot 0 is the head, FIFO among equal priorities.
// One enqueue and one dequeue per cycle; optional evict-on-full.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   i_data/i_priority/i_valid : enqueue side, o_ready accepts
//   o_data/o_priority/o_valid : show-ahead head, i_ready consumes
//   i_flush                   : drop everything (overrides enq/deq)
//   o_count, o_almost_full    : occupancy status
//   o_evict_*                 : one-cycle report of a dropped entry
// ----------------------------------------------------------------------------
module aging_free_evicting_priority_queue
    import pq_pkg::*;
#(
    parameter int DATA_WIDTH          = 8,
    parameter int PRIORITY_WIDTH      = 3,
    parameter int DEPTH               = 16,
    parameter bit HIGH_PRIORITY_FIRST = 1'b1,
    parameter bit EVICT_ON_FULL       = EVICT_MODE_BACKPRESSURE,
    parameter int ALMOST_FULL_THRESH  = DEPTH - 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         i_data,
    input  logic [PRIORITY_WIDTH-1:0]     i_priority,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic [DATA_WIDTH-1:0]         o_data,
    output logic [PRIORITY_WIDTH-1:0]     o_priority,
    output logic                          o_valid,
    input  logic                          i_ready,
    input  logic                          i_flush,
    output logic [$clog2(DEPTH+1)-1:0]    o_count,
    output logic                          o_almost_full,
    output logic                          o_evict_valid,
    output logic [DATA_WIDTH-1:0]         o_evict_data,
    output logic [PRIORITY_WIDTH-1:0]     o_evict_priority
);

    localparam int            CW   = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DEPTH-1:0][DATA_WIDTH-1:0]     slot_data, shift_data, next_data;
    logic [DEPTH-1:0][PRIORITY_WIDTH-1:0] slot_prio, shift_prio, next_prio;
    logic [CW-1:0]                        count, count_pd, count_next, ins_idx;
    logic                                 deq, enq, ins_en, evict_fire;
    logic [DATA_WIDTH-1:0]                evict_data_d;
    logic [PRIORITY_WIDTH-1:0]            evict_prio_d;
    logic                                 ev_valid_q;
    logic [DATA_WIDTH-1:0]                ev_data_q;
    logic [PRIORITY_WIDTH-1:0]            ev_prio_q;

    // ---- handshakes; flush kills both sides ------------------------------
    assign o_valid = (count != '0);
    assign o_ready = (count < FULL) || (EVICT_ON_FULL == EVICT_MODE_DROP_LOSER);
    assign deq     = o_valid && i_ready && !i_flush;
    assign enq     = i_valid && o_ready && !i_flush;

    // occupancy as seen by the insert search, after the head has left
    assign count_pd = count - CW'(deq);

    // ---- post-dequeue view: everything moves one slot toward the head ----
    for (genvar i = 0; i < DEPTH; i++) begin : g_shift
        if (i < DEPTH - 1) begin : g_mid
            assign shift_data[i] = deq ? slot_data[i+1] : slot_data[i];
            assign shift_prio[i] = deq ? slot_prio[i+1] : slot_prio[i];
        end else begin : g_last
            // stale copy of the tail when shifting; it sits at index >= count
            assign shift_data[i] = slot_data[i];
            assign shift_prio[i] = slot_prio[i];
        end
    end

    pq_insert_index #(
        .DEPTH               (DEPTH),
        .PRIORITY_WIDTH      (PRIORITY_WIDTH),
        .HIGH_PRIORITY_FIRST (HIGH_PRIORITY_FIRST)
    ) u_insert_index (
        .new_priority  (i_priority),
        .slot_priority (shift_prio),
        .count         (count_pd),
        .index         (ins_idx)
    );

    // ins_idx == DEPTH only when full and the newcomer loses to the tail:
    // nothing moves and the newcomer itself is the evicted entry.
    assign ins_en     = enq && (ins_idx != FULL);
    assign evict_fire = enq && (count_pd == FULL);
    assign count_next = count_pd + CW'(enq && (count_pd != FULL));

    assign evict_data_d = (ins_idx == FULL) ? i_data     : shift_data[DEPTH-1];
    assign evict_prio_d = (ins_idx == FULL) ? i_priority : shift_prio[DEPTH-1];

    // ---- per-slot shift/insert mux ---------------------------------------
    // above the insert point: keep; at it: new item; below it: push down one
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        if (i == 0) begin : g_head
            assign next_data[i] = (ins_en && ins_idx == '0) ? i_data     : shift_data[i];
            assign next_prio[i] = (ins_en && ins_idx == '0) ? i_priority : shift_prio[i];
        end else begin : g_body
            assign next_data[i] = !ins_en                ? shift_data[i]   :
                                  (CW'(i) == ins_idx)    ? i_data          :
                                  (CW'(i) >  ins_idx)    ? shift_data[i-1] :
                                                           shift_data[i];
            assign next_prio[i] = !ins_en                ? shift_prio[i]   :
                                  (CW'(i) == ins_idx)    ? i_priority      :
                                  (CW'(i) >  ins_idx)    ? shift_prio[i-1] :
                                                           shift_prio[i];
        end
    end

    // ---- state ------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            slot_data  <= '0;
            slot_prio  <= '0;
            ev_valid_q <= 1'b0;
            ev_data_q  <= '0;
            ev_prio_q  <= '0;
        end else if (i_flush) begin
            count      <= '0;
            ev_valid_q <= 1'b0;
        end else begin
            count      <= count_next;
            slot_data  <= next_data;
            slot_prio  <= next_prio;
            ev_valid_q <= evict_fire;
            if (evict_fire) begin
                ev_data_q <= evict_data_d;
                ev_prio_q <= evict_prio_d;
            end
        end
    end

    // ---- outputs ----------------------------------------------------------
    // head is masked so stale slot contents never reach the bus when empty
    assign o_data           = o_valid ? slot_data[0] : '0;
    assign o_priority       = o_valid ? slot_prio[0] : '0;
    assign o_count          = count;
    assign o_almost_full    = (int'(count) >= ALMOST_FULL_THRESH);
    assign o_evict_valid    = ev_valid_q;
    assign o_evict_data     = ev_data_q;
    assign o_evict_priority = ev_prio_q;

endmodule

// File: tb/tb_aging_free_evicting_priority_queue.sv
// Three instances share one stimulus stream:
//   d0: high-first, back-pressure   d1: low-first, back-pressure
//   d2: high-first, evict-on-full
// The reference model keeps an unordered set of (data, priority, arrival)
// and picks the head / loser by scanning for best / worst.
module tb_aging_free_evicting_priority_queue;

    localparam int DEPTH = 16;
    localparam int AFT   = 14;
    localparam int ND    = 3;

    logic clk, rst;
    logic [7:0] i_data;
    logic [2:0] i_priority;
    logic       i_valid, i_ready, i_flush;

    logic [ND-1:0]       o_ready, o_valid, o_almost_full, o_evict_valid;
    logic [ND-1:0][7:0]  o_data, o_evict_data;
    logic [ND-1:0][2:0]  o_priority, o_evict_priority;
    logic [ND-1:0][4:0]  o_count;

    for (genvar k = 0; k < ND; k++) begin : g_dut
        localparam bit HP = (k != 1);
        localparam bit EV = (k == 2);
        aging_free_evicting_priority_queue #(
            .DATA_WIDTH(8), .PRIORITY_WIDTH(3), .DEPTH(DEPTH),
            .HIGH_PRIORITY_FIRST(HP), .EVICT_ON_FULL(EV), .ALMOST_FULL_THRESH(AFT)
        ) u_dut (
            .clk(clk), .rst(rst),
            .i_data(i_data), .i_priority(i_priority), .i_valid(i_valid),
            .o_ready(o_ready[k]),
            .o_data(o_data[k]), .o_priority(o_priority[k]), .o_valid(o_valid[k]),
            .i_ready(i_ready), .i_flush(i_flush),
            .o_count(o_count[k]), .o_almost_full(o_almost_full[k]),
            .o_evict_valid(o_evict_valid[k]), .o_evict_data(o_evict_data[k]),
            .o_evict_priority(o_evict_priority[k])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total, bad, seq_n;

    // reference model state
    logic [7:0] md [ND][DEPTH+1];
    logic [2:0] mp [ND][DEPTH+1];
    int         ms [ND][DEPTH+1];
    int         mc [ND];
    logic       ev_v [ND];
    logic [7:0] ev_d [ND];
    logic [2:0] ev_p [ND];

    logic [7:0] exp1 [4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit tb_beats(int k, int a, int b);
        return (k != 1) ? (a > b) : (a < b);
    endfunction

    function automatic int best_idx(int k);
        int b = 0;
        for (int j = 1; j < mc[k]; j++)
            if (tb_beats(k, mp[k][j], mp[k][b]) ||
                (mp[k][j] == mp[k][b] && ms[k][j] < ms[k][b])) b = j;
        return b;
    endfunction

    function automatic int worst_idx(int k);
        int w = 0;
        for (int j = 1; j < mc[k]; j++)
            if (tb_beats(k, mp[k][w], mp[k][j]) ||
                (mp[k][j] == mp[k][w] && ms[k][j] > ms[k][w])) w = j;
        return w;
    endfunction

    task automatic remove_at(int k, int j);
        for (int t = j; t < mc[k] - 1; t++) begin
            md[k][t] = md[k][t+1]; mp[k][t] = mp[k][t+1]; ms[k][t] = ms[k][t+1];
        end
        mc[k]--;
    endtask

    task automatic model_edge(int k, bit v, logic [7:0] d, logic [2:0] p, bit r, bit f, bit rs);
        bit deq, enq;
        int w;
        if (rs) begin
            mc[k] = 0; ev_v[k] = 0; ev_d[k] = '0; ev_p[k] = '0;
        end else if (f) begin
            mc[k] = 0; ev_v[k] = 0;
        end else begin
            deq = (mc[k] > 0) && r;
            enq = v && ((mc[k] < DEPTH) || (k == 2));
            ev_v[k] = 0;
            if (deq) remove_at(k, best_idx(k));
            if (enq) begin
                md[k][mc[k]] = d; mp[k][mc[k]] = p; ms[k][mc[k]] = seq_n; mc[k]++;
                if (mc[k] > DEPTH) begin
                    w = worst_idx(k);
                    ev_v[k] = 1; ev_d[k] = md[k][w]; ev_p[k] = mp[k][w];
                    remove_at(k, w);
                end
            end
        end
    endtask

    task automatic compare(int k);
        int b;
        chk($sformatf("d%0d.count", k), 32'(o_count[k]), 32'(mc[k]));
        chk($sformatf("d%0d.valid", k), 32'(o_valid[k]), 32'(mc[k] > 0));
        chk($sformatf("d%0d.ready", k), 32'(o_ready[k]), 32'((mc[k] < DEPTH) || (k == 2)));
        chk($sformatf("d%0d.afull", k), 32'(o_almost_full[k]), 32'(mc[k] >= AFT));
        chk($sformatf("d%0d.ev_valid", k), 32'(o_evict_valid[k]), 32'(ev_v[k]));
        chk($sformatf("d%0d.ev_data", k), 32'(o_evict_data[k]), 32'(ev_d[k]));
        chk($sformatf("d%0d.ev_prio", k), 32'(o_evict_priority[k]), 32'(ev_p[k]));
        if (mc[k] > 0) begin
            b = best_idx(k);
            chk($sformatf("d%0d.head_data", k), 32'(o_data[k]), 32'(md[k][b]));
            chk($sformatf("d%0d.head_prio", k), 32'(o_priority[k]), 32'(mp[k][b]));
        end
    endtask

    task automatic step(input bit v, input logic [7:0] d, input logic [2:0] p,
                        input bit r, input bit f, input bit rs);
        i_valid = v; i_data = d; i_priority = p; i_ready = r; i_flush = f; rst = rs;
        @(posedge clk);
        #1;
        seq_n++;
        for (int k = 0; k < ND; k++) model_edge(k, v, d, p, r, f, rs);
        for (int k = 0; k < ND; k++) compare(k);
    endtask

    task automatic idle();
        step(0, 8'h00, 3'd0, 0, 0, 0);
    endtask

    initial begin
        total = 0; bad = 0; seq_n = 0;
        for (int k = 0; k < ND; k++) begin
            mc[k] = 0; ev_v[k] = 0; ev_d[k] = '0; ev_p[k] = '0;
        end
        exp1[0] = 8'hB; exp1[1] = 8'hD; exp1[2] = 8'hA; exp1[3] = 8'hC;
        i_valid = 0; i_data = '0; i_priority = '0; i_ready = 0; i_flush = 0; rst = 1;
        #2;

        // reset state
        step(0, 8'h00, 3'd0, 0, 0, 1);
        step(0, 8'h00, 3'd0, 0, 0, 1);
        chk("rst.ready", 32'(o_ready[0]), 32'd1);
        chk("rst.data", 32'(o_data[0]), 32'd0);
        chk("rst.count", 32'(o_count[0]), 32'd0);

        // high-first order with FIFO among ties
        step(1, 8'hA, 3'd3, 0, 0, 0);
        step(1, 8'hB, 3'd5, 0, 0, 0);
        step(1, 8'hC, 3'd3, 0, 0, 0);
        step(1, 8'hD, 3'd5, 0, 0, 0);
        chk("t1.count", 32'(o_count[0]), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t1.head", 32'(o_data[0]), 32'(exp1[i]));
            step(0, 8'h00, 3'd0, 1, 0, 0);
            chk("t1.count", 32'(o_count[0]), 32'(3 - i));
        end

        // low-first order
        step(1, 8'h70, 3'd7, 0, 0, 0);
        step(1, 8'h10, 3'd1, 0, 0, 0);
        step(1, 8'h40, 3'd4, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("t2.head", 32'(o_priority[1]), (i == 0) ? 32'd1 : (i == 1) ? 32'd4 : 32'd7);
            step(0, 8'h00, 3'd0, 1, 0, 0);
        end

        // simultaneous enqueue/dequeue at count 3
        step(1, 8'h21, 3'd2, 0, 0, 0);
        step(1, 8'h22, 3'd2, 0, 0, 0);
        step(1, 8'h23, 3'd2, 0, 0, 0);
        step(1, 8'h77, 3'd7, 1, 0, 0);
        chk("t3.count", 32'(o_count[0]), 32'd3);
        chk("t3.new_head", 32'(o_data[0]), 32'h77);
        for (int i = 0; i < 3; i++) begin
            step(1, 8'($urandom), 3'($urandom), 1, 0, 0);
            chk("t3.count_hold", 32'(o_count[0]), 32'd3);
        end

        // fill to full; tail priority 2 on the evicting instance
        step(0, 8'h00, 3'd0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) step(1, 8'hEE, 3'd2, 0, 0, 0);
            else                step(1, 8'(i), 3'((i % 5) + 3), 0, 0, 0);
            if (i + 1 == 13) chk("t4.afull_13", 32'(o_almost_full[0]), 32'd0);
            if (i + 1 == 14) chk("t4.afull_14", 32'(o_almost_full[0]), 32'd1);
        end
        chk("t4.ready_full", 32'(o_ready[0]), 32'd0);
        step(1, 8'h66, 3'd6, 0, 0, 0);
        chk("t4.count_bp", 32'(o_count[0]), 32'd16);
        chk("t4.ev_valid", 32'(o_evict_valid[2]), 32'd1);
        chk("t4.ev_data", 32'(o_evict_data[2]), 32'hEE);
        chk("t4.ev_prio", 32'(o_evict_priority[2]), 32'd2);
        chk("t4.count_ev", 32'(o_count[2]), 32'd16);
        step(1, 8'h22, 3'd2, 0, 0, 0);
        chk("t4.ev_self", 32'(o_evict_data[2]), 32'h22);
        chk("t4.ev_valid2", 32'(o_evict_valid[2]), 32'd1);
        idle();
        chk("t4.ev_pulse", 32'(o_evict_valid[2]), 32'd0);
        chk("t4.ev_hold", 32'(o_evict_data[2]), 32'h22);

        // reset mid-stream
        step(1, 8'h99, 3'd4, 1, 0, 1);
        for (int k = 0; k < ND; k++) begin
            chk("t6.count", 32'(o_count[k]), 32'd0);
            chk("t6.data", 32'(o_data[k]), 32'd0);
            chk("t6.prio", 32'(o_priority[k]), 32'd0);
            chk("t6.ev_data", 32'(o_evict_data[k]), 32'd0);
        end

        // flush dominates enqueue and dequeue
        for (int i = 0; i < 5; i++) step(1, 8'(8'h50 + i), 3'(i), 0, 0, 0);
        chk("t5.count5", 32'(o_count[0]), 32'd5);
        step(1, 8'h55, 3'd5, 1, 1, 0);
        for (int k = 0; k < ND; k++) begin
            chk("t5.count", 32'(o_count[k]), 32'd0);
            chk("t5.valid", 32'(o_valid[k]), 32'd0);
            chk("t5.ev_valid", 32'(o_evict_valid[k]), 32'd0);
        end

        // randomized phases: filling, draining, balanced
        for (int ph = 0; ph < 3; ph++) begin
            for (int n = 0; n < 1000; n++) begin
                int rp;
                rp = (ph == 0) ? 20 : (ph == 1) ? 85 : 50;
                step($urandom_range(99) < 75,
                     8'($urandom), 3'($urandom_range(7)),
                     $urandom_range(99) < rp,
                     $urandom_range(63) == 0,
                     $urandom_range(999) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
